// File: rtl/stream_demux_1ton_if.sv
// Handshake bundle between one producer, the 1-to-N demux and NUM_CH consumers.
// master = producer/consumer side, slave = demux side.
interface stream_demux_1ton_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic [SEL_W-1:0]         in_sel;
  logic                     in_last;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_last;
  logic                     err_sel;

  modport master (
    output in_valid, in_data, in_sel, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, err_sel
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, err_sel
  );
endinterface

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N stream demux with packet locking and a one-entry register per channel.
// Optional per-channel drain counters (beat_cnt) are enabled by defining DEMUX_BEATCNT_EN.
module stream_demux_1ton #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  stream_demux_1ton_if.slave   bus
`ifdef DEMUX_BEATCNT_EN
  ,
  output logic [NUM_CH*16-1:0] beat_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, LOCK, DROP} state_t;

  localparam logic [SEL_W:0] CH_LIMIT = (SEL_W+1)'(NUM_CH);

  function automatic logic sel_in_range(input logic [SEL_W-1:0] sel);
    return ({1'b0, sel} < CH_LIMIT);
  endfunction

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   lock_ch, lock_nxt;
  logic [SEL_W-1:0]   tgt;
  logic               sel_ok;
  logic               tgt_free;
  logic               ready;
  logic               accept;
  logic               load;
  logic [NUM_CH-1:0]  load_vec;
  logic               err_nxt;

  logic [NUM_CH-1:0]  vld_p1;
  logic [DATA_W-1:0]  data_p1 [NUM_CH];
  logic [NUM_CH-1:0]  last_p1;
  logic               err_p1;

  always_comb begin
    tgt       = (state == LOCK) ? lock_ch : bus.in_sel;
    sel_ok    = sel_in_range(bus.in_sel);
    tgt_free  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (tgt == SEL_W'(k)) tgt_free = !vld_p1[k] || bus.out_ready[k];
    end

    ready = 1'b1;
    unique case (state)
      IDLE:    ready = sel_ok ? tgt_free : 1'b1;
      LOCK:    ready = tgt_free;
      DROP:    ready = 1'b1;
      default: ready = 1'b1;
    endcase

    accept = bus.in_valid && ready;
    load   = accept && ((state == LOCK) || ((state == IDLE) && sel_ok));
    load_vec = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (load && (tgt == SEL_W'(k))) load_vec[k] = 1'b1;
    end

    state_nxt = state;
    lock_nxt  = lock_ch;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (sel_ok) begin
            if (accept && !bus.in_last) begin
              state_nxt = LOCK;
              lock_nxt  = bus.in_sel;
            end
          end else begin
            // Bad head: swallow it and the rest of its packet, flag once.
            err_nxt = 1'b1;
            if (!bus.in_last) state_nxt = DROP;
          end
        end
      end
      LOCK: if (accept && bus.in_last) state_nxt = IDLE;
      DROP: if (bus.in_valid && bus.in_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lock_ch <= '0;
      err_p1  <= 1'b0;
    end else begin
      state   <= state_nxt;
      lock_ch <= lock_nxt;
      err_p1  <= err_nxt;
    end
  end

  // Stage p1: per-channel output register, loaded on accept, cleared on drain.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (rst) begin
        vld_p1[k]  <= 1'b0;
        data_p1[k] <= '0;
        last_p1[k] <= 1'b0;
      end else if (load_vec[k]) begin
        vld_p1[k]  <= 1'b1;
        data_p1[k] <= bus.in_data;
        last_p1[k] <= bus.in_last;
      end else if (bus.out_ready[k]) begin
        vld_p1[k]  <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int k = 0; k < NUM_CH; k++) bus.out_data[k*DATA_W +: DATA_W] = data_p1[k];
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = vld_p1;
  assign bus.out_last  = last_p1;
  assign bus.err_sel   = err_p1;

`ifdef DEMUX_BEATCNT_EN
  logic [15:0] cnt_p1 [NUM_CH];

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (rst) begin
        cnt_p1[k] <= '0;
      end else if (vld_p1[k] && bus.out_ready[k]) begin
        cnt_p1[k] <= cnt_p1[k] + 16'd1;
      end
    end
  end

  always_comb begin
    beat_cnt = '0;
    for (int k = 0; k < NUM_CH; k++) beat_cnt[k*16 +: 16] = cnt_p1[k];
  end
`endif

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Directed scoreboard bench for stream_demux_1ton (6 channels, 3-bit select).
module tb_stream_demux_1ton;
  localparam int DATA_W = 8;
  localparam int NUM_CH = 6;
  localparam int SEL_W  = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cur_exp  = -1;
  bit   hs;
  int   waited;
  logic [DATA_W:0] sbq [NUM_CH][$];
  logic [DATA_W:0] e;

  stream_demux_1ton_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) bus ();

`ifdef DEMUX_BEATCNT_EN
  logic [NUM_CH*16-1:0] beat_cnt;
`endif

  stream_demux_1ton #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef DEMUX_BEATCNT_EN
    ,
    .beat_cnt (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Negedge: compare draining beats against the scoreboard, record the accept.
  task automatic cyc();
    @(negedge clk);
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.out_valid[k] && bus.out_ready[k]) begin
        chk($sformatf("sb_has_ch%0d", k), 64'(sbq[k].size() != 0), 64'd1);
        if (sbq[k].size() != 0) begin
          e = sbq[k].pop_front();
          chk($sformatf("beat_ch%0d", k),
              64'({bus.out_last[k], bus.out_data[k*DATA_W +: DATA_W]}), 64'(e));
        end
      end
    end
    hs = bus.in_valid && bus.in_ready;
    if (hs && cur_exp >= 0) sbq[cur_exp].push_back({bus.in_last, bus.in_data});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input int data, input bit last, input int expch);
    bus.in_valid = 1'b1;
    bus.in_sel   = SEL_W'(sel);
    bus.in_data  = DATA_W'(data);
    bus.in_last  = last;
    cur_exp      = expch;
  endtask

  task automatic send(input int sel, input int data, input bit last, input int expch,
                      output int cycles);
    drive(sel, data, last, expch);
    cycles = 0;
    hs = 1'b0;
    while (!hs && cycles < 20) begin
      cyc();
      cycles++;
    end
    chk("send_accept", 64'(hs), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sel    = '0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = '1;
    cyc();
    cyc();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_last",  64'(bus.out_last),  64'd0);
    chk("rst_out_data",  64'(bus.out_data),  64'd0);
    chk("rst_err_sel",   64'(bus.err_sel),   64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    rst = 1'b0;
    cyc();

    // Single-beat packets to every valid channel.
    for (int s = 0; s < NUM_CH; s++) begin
      send(s, 8'hA0 + s, 1'b1, s, waited);
      chk($sformatf("t1_wait_ch%0d", s), 64'(waited), 64'd1);
      chk($sformatf("t1_onehot_ch%0d", s), 64'(bus.out_valid), 64'(1 << s));
    end
    // Out-of-range single-beat heads.
    send(6, 8'hA6, 1'b1, -1, waited);
    chk("t1_err_sel6", 64'(bus.err_sel), 64'd1);
    chk("t1_noval_sel6", 64'(bus.out_valid), 64'd0);
    cyc();
    chk("t1_err_clear", 64'(bus.err_sel), 64'd0);
    send(7, 8'hA7, 1'b1, -1, waited);
    chk("t1_err_sel7", 64'(bus.err_sel), 64'd1);
    cyc();

    // Locked packet: select changes after the head are ignored.
    send(3, 8'h30, 1'b0, 3, waited);
    send(5, 8'h31, 1'b0, 3, waited);
    send(5, 8'h32, 1'b0, 3, waited);
    send(5, 8'h33, 1'b1, 3, waited);
    chk("t2_last_ch3", 64'(bus.out_valid), 64'(1 << 3));
    send(5, 8'h55, 1'b1, 5, waited);
    chk("t2_back_idle", 64'(bus.out_valid), 64'(1 << 5));
    cyc();

    // Backpressure on channel 2, then drain and reload in the same cycle.
    bus.out_ready[2] = 1'b0;
    send(2, 8'h21, 1'b1, 2, waited);
    drive(2, 8'h22, 1'b1, 2);
    #1;
    chk("t3_blocked", 64'(bus.in_ready), 64'd0);
    cyc();
    chk("t3_still_blocked", 64'(bus.in_ready), 64'd0);
    chk("t3_hold_data", 64'(bus.out_data[2*DATA_W +: DATA_W]), 64'h21);
    bus.out_ready[2] = 1'b1;
    #1;
    chk("t3_ready_on_drain", 64'(bus.in_ready), 64'd1);
    cyc();
    bus.in_valid = 1'b0;
    chk("t3_no_bubble_vld", 64'(bus.out_valid[2]), 64'd1);
    chk("t3_no_bubble_data", 64'(bus.out_data[2*DATA_W +: DATA_W]), 64'h22);
    cyc();

    // Dropped 3-beat packet, then a normal one.
    send(7, 8'h70, 1'b0, -1, waited);
    chk("t4_err_head", 64'(bus.err_sel), 64'd1);
    send(1, 8'h71, 1'b0, -1, waited);
    chk("t4_drop_wait", 64'(waited), 64'd1);
    chk("t4_err_once", 64'(bus.err_sel), 64'd0);
    chk("t4_drop_noval", 64'(bus.out_valid), 64'd0);
    send(1, 8'h72, 1'b1, -1, waited);
    chk("t4_err_tail", 64'(bus.err_sel), 64'd0);
    chk("t4_tail_noval", 64'(bus.out_valid), 64'd0);
    send(1, 8'h1F, 1'b1, 1, waited);
    chk("t4_after_drop", 64'(bus.out_valid), 64'(1 << 1));
    cyc();

    // Reset in the middle of a packet locked to channel 4.
    bus.out_ready[4] = 1'b0;
    send(4, 8'h40, 1'b0, 4, waited);
    drive(0, 8'h41, 1'b0, -1);
    rst = 1'b1;
    cyc();
    chk("t5_rst_clear", 64'(bus.out_valid), 64'd0);
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = '1;
    for (int k = 0; k < NUM_CH; k++) sbq[k].delete();
    send(0, 8'h0F, 1'b1, 0, waited);
    chk("t5_head_ch0", 64'(bus.out_valid), 64'd1);
    cyc();

`ifdef DEMUX_BEATCNT_EN
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 65537; i++) send(1, i, 1'b1, 1, waited);
    cyc();
    cyc();
    chk("cnt_ch1_wrap", 64'(beat_cnt[1*16 +: 16]), 64'h0001);
    for (int k = 0; k < NUM_CH; k++) begin
      if (k != 1) chk($sformatf("cnt_ch%0d_zero", k), 64'(beat_cnt[k*16 +: 16]), 64'd0);
    end
`endif

    cyc();
    chk("end_idle", 64'(bus.out_valid), 64'd0);
    for (int k = 0; k < NUM_CH; k++)
      chk($sformatf("sb_empty_ch%0d", k), 64'(sbq[k].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stream_demux_1ton.md
Name: stream_demux_1toN

Overview:
- Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshakes and packet locking.
- Routes each input beat to one of NUM_CH output channels, selected by in_sel.
- Holds the selection for a whole packet, from the first beat to the in_last beat.
- Successor to the team's combinational demux trees; sits between a single producer and NUM_CH independent consumers.

Parameters:
- DATA_W, 8, payload width in bits.
- NUM_CH, 8, number of output channels, 2..16; need not be a power of two.
- SEL_W, 3, select width; constraint 2**SEL_W >= NUM_CH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept the beat this cycle.
- in_data  input  DATA_W  input payload.
- in_sel  input  SEL_W  destination channel; sampled only on a packet's first beat.
- in_last  input  1  marks the final beat of a packet.
- out_valid  output  NUM_CH  per-channel valid.
- out_ready  input  NUM_CH  per-channel ready.
- out_data  output  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- out_last  output  NUM_CH  per-channel last flag.
- err_sel  output  1  one-cycle pulse: a packet head carried an out-of-range select.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_last=0, err_sel=0, FSM=IDLE, lock_ch=0. in_ready is combinational and evaluates to 1 in reset-exit IDLE.
- Reset mid-packet discards all buffered beats and the lock; the next beat is treated as a packet head.
- Each channel has a one-entry output register (valid, data, last).
- Channel k drains when out_valid[k] & out_ready[k]; after the drain, out_valid[k]=0 unless it is reloaded in the same cycle.
- Target channel: in_sel in IDLE, lock_ch in LOCK.
- in_ready = target register empty OR target draining this cycle. This is a combinational path from out_ready[target] to in_ready.
- Accept = in_valid & in_ready. The beat is loaded into the target register on that edge, so out_valid rises the next cycle (latency 1).
- Sustained throughput is one beat per cycle per channel while out_ready stays high.
- At most one channel is loaded per cycle. Other channels drain independently, with no ordering between channels.
- out_data[k] and out_last[k] hold their values while out_valid[k]=0.
- FSM states: IDLE, LOCK, DROP.
  - IDLE, accept with in_sel < NUM_CH: load the beat. If in_last=0, go to LOCK with lock_ch=in_sel; if in_last=1, stay in IDLE (single-beat packet).
  - IDLE, in_valid with in_sel >= NUM_CH: in_ready=1 and the beat is discarded. err_sel=1 on the next cycle. Go to DROP if in_last=0, otherwise stay in IDLE.
  - LOCK: in_sel is ignored. Accept with in_last=1 returns to IDLE; other accepts stay in LOCK.
  - DROP: in_ready=1 and all beats are discarded. in_valid & in_last returns to IDLE. err_sel does not pulse again.
- in_valid=0: no state change; in_data, in_sel and in_last are don't-care.
- Out-of-range select is only reachable when NUM_CH < 2**SEL_W.

Optional Feature:
- Macro: DEMUX_BEATCNT_EN.
- Defined: adds output port beat_cnt, NUM_CH*16 bits. Channel k's counter at [k*16 +: 16] increments on each out_valid[k] & out_ready[k], wraps from 0xFFFF to 0x0000, and is cleared by rst.
- Undefined: port and counters absent; all other behaviour identical.

Test Plan:
- All out_ready=1; send single-beat packets with sel 0..7 and data 0xA0+sel, in_last=1 -> each channel shows exactly one out_valid one cycle after accept, with the matching data; in_ready stays 1.
- 4-beat packet with sel=3 on the first beat and sel=5 on beats 2-4 -> all four beats appear on channel 3 in order, out_last only on beat 4; channel 5 never valid.
- out_ready[2]=0 and two beats to channel 2 -> first beat buffered, in_ready=0 for the second; raise out_ready[2] -> second beat accepted in the same cycle as the drain, no bubble.
- NUM_CH=6, SEL_W=3, 3-beat packet with sel=7 -> err_sel pulses once, no out_valid on any channel, FSM returns to IDLE after the last beat; next packet with sel=1 is delivered normally.
- Assert rst during beat 2 of a locked packet to channel 4 -> all out_valid=0 the next cycle; a following beat with sel=0, in_last=1 goes to channel 0.
- DEMUX_BEATCNT_EN defined: 65537 handshakes on channel 1 -> beat_cnt for channel 1 = 0x0001, other channels 0.
